// File: rtl/store_lane_packer_if.sv
// Store-request / data-memory write bundle for store_lane_packer.
//   master : MEM-stage + memory side (drives requests, drives mem_ready)
//   slave  : the packer (accepts requests, issues memory writes, flags errors)
// Signals:
//   req_valid/req_ready/req_addr/req_data/req_size  store request handshake
//   mem_valid/mem_ready/mem_addr/mem_wdata/mem_be   data-memory write handshake
//   err/err_addr                                    misalignment / illegal-size report
interface store_lane_packer_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              err;
  logic [ADDR_W-1:0] err_addr;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, err, err_addr
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, err, err_addr
  );
endinterface

// File: rtl/store_lane_packer.sv
// store_lane_packer: narrows a register value to SB/SH/SW, places it in the
// correct byte lanes with byte enables, queues it in a DEPTH-entry FIFO and
// issues it to data memory over valid/ready.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  store_lane_packer_if.slave (request side in, memory side out, err)
// Optional build macro: STORE_SPLIT_EN
//   undefined : misaligned half/word requests are rejected with an err pulse
//   defined   : half at lane 1 is a single write; half at lane 3 and word at
//               lane != 0 are split into two word-aligned writes
module store_lane_packer #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input logic                clk,
  input logic                rst,
  store_lane_packer_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     wr_ptr1;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [31:0]       wdata_q [DEPTH];
  logic [3:0]        be_q    [DEPTH];
  logic              err_r;
  logic [ADDR_W-1:0] err_addr_r;

  logic [1:0]        lane;
  logic [ADDR_W-1:0] waddr;
  logic              legal;
  logic              two;
  logic [3:0]        be0;
  logic [3:0]        be1;
  logic [31:0]       wd0;
  logic [31:0]       wd1;
  logic              ready;
  logic              acc;
  logic              pop;
  logic [1:0]        push_n;
`ifdef STORE_SPLIT_EN
  logic [31:0]       datum;
  logic [2:0]        rem;
`endif

  // Request formatting: everything below is decided combinationally from the
  // request and written into the FIFO at the accepting edge.
  always_comb begin
    lane  = bus.req_addr[1:0];
    waddr = {bus.req_addr[ADDR_W-1:2], 2'b00};
    legal = 1'b0;
    two   = 1'b0;
    be0   = 4'b0000;
    be1   = 4'b0000;
    wd0   = 32'h0;
    wd1   = 32'h0;
`ifdef STORE_SPLIT_EN
    datum = (bus.req_size == 2'b01) ? {16'h0, bus.req_data[15:0]} : bus.req_data;
    rem   = 3'd4 - {1'b0, lane};
`endif
    case (bus.req_size)
      2'b00: begin
        legal = 1'b1;
        be0   = 4'b0001 << lane;
        wd0   = {4{bus.req_data[7:0]}};
      end
      2'b01: begin
        // Aligned halves sit at lane 0 or 2, where the rotation is zero.
        if (!lane[0]) begin
          legal = 1'b1;
          be0   = 4'b0011 << lane;
          wd0   = {2{bus.req_data[15:0]}};
        end
`ifdef STORE_SPLIT_EN
        else if (lane == 2'd1) begin
          legal = 1'b1;
          be0   = 4'b0110;
          wd0   = {8'h0, bus.req_data[15:0], 8'h0};
        end else begin
          legal = 1'b1;
          two   = 1'b1;
        end
`endif
      end
      2'b10: begin
        if (lane == 2'd0) begin
          legal = 1'b1;
          be0   = 4'b1111;
          wd0   = bus.req_data;
        end
`ifdef STORE_SPLIT_EN
        else begin
          legal = 1'b1;
          two   = 1'b1;
        end
`endif
      end
      default: ;
    endcase
`ifdef STORE_SPLIT_EN
    // Split: the low bytes of the datum fill the top lanes of this word,
    // the leftover high bytes start at lane 0 of the next word.
    if (two) begin
      be0 = 4'b1111 << lane;
      wd0 = datum << {lane, 3'b000};
      be1 = (bus.req_size == 2'b01) ? 4'b0001 : ~be0;
      wd1 = datum >> {rem, 3'b000};
    end
`endif
  end

  // Two free slots are demanded so a split never has to look at occupancy.
  assign ready   = !rst && (count <= CW'(DEPTH - 2));
  assign acc     = bus.req_valid && ready;
  assign pop     = (count != '0) && bus.mem_ready;
  assign push_n  = (acc && legal) ? (two ? 2'd2 : 2'd1) : 2'd0;
  assign wr_ptr1 = wr_ptr + PW'(1);

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      err_r      <= 1'b0;
      err_addr_r <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      wr_ptr <= wr_ptr + PW'(push_n);
      count  <= count + CW'(push_n) - CW'(pop);
      err_r  <= acc && !legal;
      if (acc && !legal) err_addr_r <= bus.req_addr;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (acc && legal) begin
      addr_q[wr_ptr]  <= waddr;
      wdata_q[wr_ptr] <= wd0;
      be_q[wr_ptr]    <= be0;
      if (two) begin
        addr_q[wr_ptr1]  <= waddr + ADDR_W'(4);
        wdata_q[wr_ptr1] <= wd1;
        be_q[wr_ptr1]    <= be1;
      end
    end
  end

  // Outputs: head of the FIFO; stale when empty.
  assign bus.req_ready = ready;
  assign bus.mem_valid = (count != '0);
  assign bus.mem_addr  = addr_q[rd_ptr];
  assign bus.mem_wdata = wdata_q[rd_ptr];
  assign bus.mem_be    = be_q[rd_ptr];
  assign bus.err       = err_r;
  assign bus.err_addr  = err_addr_r;

endmodule

// File: tb/tb_store_lane_packer.sv
module tb_store_lane_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  store_lane_packer_if #(.ADDR_W(32)) bus ();

  store_lane_packer #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                     input logic v, input logic [31:0] ea, input logic [3:0] eb,
                     input logic [31:0] ew, input logic e);
    vec_t t;
    t.size = s; t.addr = a; t.data = d; t.exp_valid = v;
    t.exp_addr = ea; t.exp_be = eb; t.exp_wdata = ew; t.exp_err = e;
    vecs.push_back(t);
  endtask

  task automatic drive_req(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_size  = s;
    bus.req_addr  = a;
    bus.req_data  = d;
  endtask

`ifdef STORE_SPLIT_EN
  task automatic split_seq(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] a0, input logic [3:0] b0, input logic [31:0] w0,
                           input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] w1);
    bus.mem_ready = 1'b0;
    drive_req(s, a, d);
    tick();
    bus.req_valid = 1'b0;
    check("split_v0", bus.mem_valid, 1'b1);
    check("split_a0", bus.mem_addr, a0);
    check("split_b0", bus.mem_be, b0);
    check("split_w0", bus.mem_wdata, w0);
    check("split_full", bus.req_ready, 1'b0);
    bus.mem_ready = 1'b1;
    tick();
    check("split_v1", bus.mem_valid, 1'b1);
    check("split_a1", bus.mem_addr, a1);
    check("split_b1", bus.mem_be, b1);
    check("split_w1", bus.mem_wdata, w1);
    tick();
    check("split_empty", bus.mem_valid, 1'b0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = 2'b00;
    bus.mem_ready = 1'b0;

    // Vector table: {size, addr, data, exp_valid, exp_addr, exp_be, exp_wdata, exp_err}
    add(2'b00, 32'h0000_0103, 32'hAABB_CCDD, 1, 32'h0000_0100, 4'b1000, 32'hDDDD_DDDD, 0);
    add(2'b01, 32'h0000_0202, 32'h1234_BEEF, 1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 0);
    add(2'b10, 32'h0000_0300, 32'hCAFE_F00D, 1, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 0);
    add(2'b00, 32'h0000_0000, 32'h1234_5678, 1, 32'h0000_0000, 4'b0001, 32'h7878_7878, 0);
    add(2'b01, 32'h0000_0010, 32'h0000_A55A, 1, 32'h0000_0010, 4'b0011, 32'hA55A_A55A, 0);
    add(2'b00, 32'h0FFF_FFFE, 32'h0000_009C, 1, 32'h0FFF_FFFC, 4'b0100, 32'h9C9C_9C9C, 0);
    add(2'b11, 32'h0000_0600, 32'h1111_1111, 0, 32'h0,         4'b0000, 32'h0,         1);
    add(2'b11, 32'h0000_0602, 32'h2222_2222, 0, 32'h0,         4'b0000, 32'h0,         1);
`ifdef STORE_SPLIT_EN
    add(2'b01, 32'h0000_0405, 32'h0000_ABCD, 1, 32'h0000_0404, 4'b0110, 32'h00AB_CD00, 0);
`else
    add(2'b10, 32'h0000_0401, 32'h1122_3344, 0, 32'h0,         4'b0000, 32'h0,         1);
    add(2'b01, 32'h0000_0405, 32'h0000_ABCD, 0, 32'h0,         4'b0000, 32'h0,         1);
    add(2'b01, 32'h0000_0407, 32'h0000_ABCD, 0, 32'h0,         4'b0000, 32'h0,         1);
    add(2'b10, 32'h0000_0402, 32'h1122_3344, 0, 32'h0,         4'b0000, 32'h0,         1);
`endif

    // Reset state
    tick();
    tick();
    check("rst_mem_valid", bus.mem_valid, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_err_addr", bus.err_addr, 32'h0);
    check("rst_req_ready", bus.req_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", bus.req_ready, 1'b1);

    // Single-request vectors with memory always ready
    for (int i = 0; i < vecs.size(); i++) begin
      bus.mem_ready = 1'b1;
      drive_req(vecs[i].size, vecs[i].addr, vecs[i].data);
      tick();
      bus.req_valid = 1'b0;
      check($sformatf("v%0d_valid", i), bus.mem_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].exp_addr);
        check($sformatf("v%0d_be", i), bus.mem_be, vecs[i].exp_be);
        check($sformatf("v%0d_wdata", i), bus.mem_wdata, vecs[i].exp_wdata);
      end
      check($sformatf("v%0d_err", i), bus.err, vecs[i].exp_err);
      if (vecs[i].exp_err)
        check($sformatf("v%0d_err_addr", i), bus.err_addr, vecs[i].addr);
      tick();
      check($sformatf("v%0d_drained", i), bus.mem_valid, 1'b0);
      check($sformatf("v%0d_err_off", i), bus.err, 1'b0);
    end

    // Back-to-back illegal requests: two consecutive pulses, err_addr follows
    drive_req(2'b11, 32'h0000_0700, 32'h0);
    tick();
    check("b2b_err1", bus.err, 1'b1);
    check("b2b_addr1", bus.err_addr, 32'h0000_0700);
    drive_req(2'b11, 32'h0000_0704, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    check("b2b_err2", bus.err, 1'b1);
    check("b2b_addr2", bus.err_addr, 32'h0000_0704);
    tick();
    check("b2b_err_off", bus.err, 1'b0);
    check("b2b_addr_hold", bus.err_addr, 32'h0000_0704);

    // Backpressure, in-order drain and pointer wrap over 5 stores
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = 1'b0;
      drive_req(2'b10, 32'h0000_0800 + 32'(i * 4), 32'h5000_0000 + 32'(i));
      tick();
      bus.req_valid = 1'b0;
      check($sformatf("bp%0d_valid", i), bus.mem_valid, 1'b1);
      check($sformatf("bp%0d_full", i), bus.req_ready, 1'b0);
      tick();
      check($sformatf("bp%0d_hold_v", i), bus.mem_valid, 1'b1);
      check($sformatf("bp%0d_addr", i), bus.mem_addr, 32'h0000_0800 + 32'(i * 4));
      check($sformatf("bp%0d_wdata", i), bus.mem_wdata, 32'h5000_0000 + 32'(i));
      check($sformatf("bp%0d_be", i), bus.mem_be, 4'b1111);
      bus.mem_ready = 1'b1;
      tick();
      check($sformatf("bp%0d_popped", i), bus.mem_valid, 1'b0);
      check($sformatf("bp%0d_ready", i), bus.req_ready, 1'b1);
    end

`ifdef STORE_SPLIT_EN
    split_seq(2'b10, 32'h0000_0501, 32'h1122_3344,
              32'h0000_0500, 4'b1110, 32'h2233_4400,
              32'h0000_0504, 4'b0001, 32'h0000_0011);
    split_seq(2'b01, 32'h0000_0507, 32'h0000_ABCD,
              32'h0000_0504, 4'b1000, 32'hCD00_0000,
              32'h0000_0508, 4'b0001, 32'h0000_00AB);
    split_seq(2'b10, 32'hFFFF_FFFF, 32'hA1B2_C3D4,
              32'hFFFF_FFFC, 4'b1000, 32'hD400_0000,
              32'h0000_0000, 4'b0111, 32'h00A1_B2C3);
`endif

    // Reset with work queued: queue discarded, err cleared
    bus.mem_ready = 1'b0;
`ifdef STORE_SPLIT_EN
    drive_req(2'b10, 32'h0000_0901, 32'hDEAD_BEEF);
`else
    drive_req(2'b10, 32'h0000_0900, 32'hDEAD_BEEF);
`endif
    tick();
    check("q_before_rst", bus.mem_valid, 1'b1);
    drive_req(2'b11, 32'h0000_0A00, 32'h0);
    rst = 1'b1;
    #1;
    check("rst_ready_comb", bus.req_ready, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    check("rst_q_valid", bus.mem_valid, 1'b0);
    check("rst_q_err", bus.err, 1'b0);
    check("rst_q_err_addr", bus.err_addr, 32'h0);
    rst = 1'b0;
    tick();
    check("after_rst_valid", bus.mem_valid, 1'b0);
    check("after_rst_err", bus.err, 1'b0);
    bus.mem_ready = 1'b1;
    drive_req(2'b00, 32'h0000_0103, 32'hAABB_CCDD);
    tick();
    bus.req_valid = 1'b0;
    check("fresh_valid", bus.mem_valid, 1'b1);
    check("fresh_addr", bus.mem_addr, 32'h0000_0100);
    check("fresh_be", bus.mem_be, 4'b1000);
    check("fresh_wdata", bus.mem_wdata, 32'hDDDD_DDDD);
    tick();
    check("fresh_drained", bus.mem_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
